// File: rtl/rst_seq.sv
// Reset sequencer: synchronises the external reset, then releases NUM_DOMAINS
// active-low domain resets one by one with a programmable spacing. Optional
// per-domain software reset (4-phase req/ack) is compiled in with the macro
// RST_SEQ_SWRST_EN; without it the request port is ignored and ack reads 0.
// test_mode_i bypasses the sequencer: every domain reset follows rst_ni.

// One reset domain: registered release bit plus the scan bypass mux.
module rst_seq_lane (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic test_mode_i,
  input  logic set_i,
  input  logic clr_i,
  output logic rst_no
);

  logic rst_q;

  // Domain reset state: cleared asynchronously, set/cleared by the sequencer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     rst_q <= 1'b0;
    else if (clr_i)  rst_q <= 1'b0;
    else if (set_i)  rst_q <= 1'b1;
  end

  assign rst_no = test_mode_i ? rst_ni : rst_q;

endmodule

module rst_seq #(
  parameter int NUM_DOMAINS = 4,
  parameter int DELAY_W     = 8,
  parameter int SW_HOLD     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic [DELAY_W-1:0]     release_delay_i,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] sw_rst_ack_o,
  output logic [NUM_DOMAINS-1:0] rst_no,
  output logic                   init_no,
  output logic                   busy_o
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [7:0]       HOLD_INIT = 8'(SW_HOLD - 1);

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    RELEASE = 3'd1,
    RUN     = 3'd2,
    SWRST   = 3'd3,
    SWACK   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync_meta_q;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DELAY_W-1:0]     cnt_q, cnt_d;
  logic [7:0]             hold_q, hold_d;
  logic [IDX_W-1:0]       k_q, k_d;
  logic [NUM_DOMAINS-1:0] ack_q, ack_d;
  logic                   init_q, init_d;
  logic                   busy_q, busy_d;
  logic [NUM_DOMAINS-1:0] rel_set, rel_clr;

  // First synchroniser stage for the reset release; the state register
  // samples this flop, so it acts as the second stage and SYNC is left on
  // the second edge after rst_ni rises.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_meta_q <= 1'b0;
    else         sync_meta_q <= 1'b1;
  end

`ifdef RST_SEQ_SWRST_EN
  logic [IDX_W-1:0] k_sel;

  // Lowest-index pending software request wins.
  always_comb begin
    k_sel = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (sw_rst_req_i[i]) k_sel = IDX_W'(i);
    end
  end
`else
  logic unused_sw_req;
  assign unused_sw_req = ^sw_rst_req_i;
`endif

  // FSM state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SYNC;
      idx_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      k_q     <= '0;
      ack_q   <= '0;
      init_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      k_q     <= k_d;
      ack_q   <= ack_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; domain bits are changed through per-lane set/clr strobes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    k_d     = k_q;
    ack_d   = ack_q;
    init_d  = init_q;
    busy_d  = busy_q;
    rel_set = '0;
    rel_clr = '0;
    case (state_q)
      SYNC: begin
        if (sync_meta_q) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = release_delay_i;
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          rel_set[idx_q] = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = RUN;
            init_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = release_delay_i;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
`ifdef RST_SEQ_SWRST_EN
        if (|sw_rst_req_i) begin
          k_d            = k_sel;
          rel_clr[k_sel] = 1'b1;
          busy_d         = 1'b1;
          hold_d         = HOLD_INIT;
          state_d        = SWRST;
        end
`endif
      end
`ifdef RST_SEQ_SWRST_EN
      SWRST: begin
        if (hold_q == '0) begin
          rel_set[k_q] = 1'b1;
          ack_d[k_q]   = 1'b1;
          state_d      = SWACK;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      SWACK: begin
        if (!sw_rst_req_i[k_q]) begin
          ack_d   = '0;
          busy_d  = 1'b0;
          state_d = RUN;
        end
      end
`endif
      default: state_d = SYNC;
    endcase
  end

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_lane
    rst_seq_lane u_lane (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .test_mode_i (test_mode_i),
      .set_i       (rel_set[g]),
      .clr_i       (rel_clr[g]),
      .rst_no      (rst_no[g])
    );
  end

`ifdef RST_SEQ_SWRST_EN
  assign sw_rst_ack_o = ack_q;
`else
  assign sw_rst_ack_o = '0;
`endif
  assign init_no = test_mode_i | init_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq (default parameters). The software-reset
// scenario is selected by RST_SEQ_SWRST_EN to match the RTL build.
module tb_rst_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       test_mode_i;
  logic [7:0] release_delay_i;
  logic [3:0] sw_rst_req_i;
  logic [3:0] sw_rst_ack_o;
  logic [3:0] rst_no;
  logic       init_no;
  logic       busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  rst_seq #(.NUM_DOMAINS(4), .DELAY_W(8), .SW_HOLD(16)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .test_mode_i     (test_mode_i),
    .release_delay_i (release_delay_i),
    .sw_rst_req_i    (sw_rst_req_i),
    .sw_rst_ack_o    (sw_rst_ack_o),
    .rst_no          (rst_no),
    .init_no         (init_no),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Deassert reset and follow the release for n_edges edges. SYNC is left on
  // edge 2; domain i rises on edge 2 + (i+1)*(d+1).
  task automatic run_release(input int d, input int n_edges);
    int n;
    logic [3:0] exp;
    release_delay_i = 8'(d);
    rst_ni = 1'b1;
    for (int e = 1; e <= n_edges; e++) begin
      tick();
      n = (e < 2) ? 0 : (e - 2) / (d + 1);
      if (n > 4) n = 4;
      exp = 4'((1 << n) - 1);
      check($sformatf("rel d%0d e%0d rst", d, e), 32'(rst_no), 32'(exp));
      check($sformatf("rel d%0d e%0d init", d, e), 32'(init_no), (n == 4) ? 32'd1 : 32'd0);
      check($sformatf("rel d%0d e%0d busy", d, e), 32'(busy_o), (n == 4) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic pulse_reset();
    #2 rst_ni = 1'b0;
    #1;
    check("async rst", 32'(rst_no), 32'h0);
    check("async init", 32'(init_no), 32'h0);
    check("async busy", 32'(busy_o), 32'h1);
    check("async ack", 32'(sw_rst_ack_o), 32'h0);
    tick();
  endtask

  initial begin
    rst_ni          = 1'b0;
    test_mode_i     = 1'b0;
    release_delay_i = 8'd3;
    sw_rst_req_i    = '0;

    repeat (3) tick();
    check("reset rst", 32'(rst_no), 32'h0);
    check("reset init", 32'(init_no), 32'h0);
    check("reset busy", 32'(busy_o), 32'h1);
    check("reset ack", 32'(sw_rst_ack_o), 32'h0);

    // Requests during the power-on sequence are ignored.
    sw_rst_req_i = 4'h0;
    run_release(3, 20);

    // Delay 0: one domain per edge.
    pulse_reset();
    run_release(0, 8);

    // Abort while domain 2 is still pending, restart from domain 0.
    pulse_reset();
    run_release(3, 11);
    check("pre-abort rst", 32'(rst_no), 32'h3);
    pulse_reset();
    run_release(3, 19);

    // Scan bypass: domains follow rst_ni with no clock.
    test_mode_i = 1'b1;
    #1;
    check("tm hi rst", 32'(rst_no), 32'hF);
    check("tm hi init", 32'(init_no), 32'h1);
    rst_ni = 1'b0;
    #1;
    check("tm lo rst", 32'(rst_no), 32'h0);
    check("tm lo init", 32'(init_no), 32'h1);
    check("tm lo busy", 32'(busy_o), 32'h1);
    rst_ni = 1'b1;
    #1;
    check("tm hi2 rst", 32'(rst_no), 32'hF);
    check("tm hi2 init", 32'(init_no), 32'h1);
    tick();
    test_mode_i = 1'b0;
    #1;
    check("tm off rst", 32'(rst_no), 32'h0);
    check("tm off init", 32'(init_no), 32'h0);
    repeat (20) tick();
    check("tm seq rst", 32'(rst_no), 32'hF);
    check("tm seq init", 32'(init_no), 32'h1);
    check("tm seq busy", 32'(busy_o), 32'h0);

`ifdef RST_SEQ_SWRST_EN
    // Two pending requests: domain 1 first, then domain 2.
    sw_rst_req_i = 4'b0110;
    for (int e = 1; e <= 17; e++) begin
      tick();
      check($sformatf("sw1 e%0d rst", e), 32'(rst_no), (e < 17) ? 32'hD : 32'hF);
      check($sformatf("sw1 e%0d ack", e), 32'(sw_rst_ack_o), (e < 17) ? 32'h0 : 32'h2);
      check($sformatf("sw1 e%0d busy", e), 32'(busy_o), 32'h1);
      check($sformatf("sw1 e%0d init", e), 32'(init_no), 32'h1);
    end
    repeat (2) tick();
    check("sw1 hold ack", 32'(sw_rst_ack_o), 32'h2);
    check("sw1 hold busy", 32'(busy_o), 32'h1);
    sw_rst_req_i = 4'b0100;
    tick();
    check("sw1 done ack", 32'(sw_rst_ack_o), 32'h0);
    check("sw1 done busy", 32'(busy_o), 32'h0);
    check("sw1 done rst", 32'(rst_no), 32'hF);
    for (int e = 1; e <= 17; e++) begin
      tick();
      check($sformatf("sw2 e%0d rst", e), 32'(rst_no), (e < 17) ? 32'hB : 32'hF);
      check($sformatf("sw2 e%0d ack", e), 32'(sw_rst_ack_o), (e < 17) ? 32'h0 : 32'h4);
      check($sformatf("sw2 e%0d busy", e), 32'(busy_o), 32'h1);
    end
    sw_rst_req_i = 4'b0000;
    tick();
    check("sw2 done ack", 32'(sw_rst_ack_o), 32'h0);
    check("sw2 done busy", 32'(busy_o), 32'h0);
    tick();
    check("sw idle rst", 32'(rst_no), 32'hF);
`else
    // Without software reset support requests have no effect.
    sw_rst_req_i = 4'hF;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("nosw e%0d rst", e), 32'(rst_no), 32'hF);
      check($sformatf("nosw e%0d ack", e), 32'(sw_rst_ack_o), 32'h0);
      check($sformatf("nosw e%0d busy", e), 32'(busy_o), 32'h0);
    end
    sw_rst_req_i = 4'h0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
